// File: rtl/data_mem_port_if.sv
// Request, response and byte-bank signals between the load/store stage, data_mem_port and the four banks.
// slave: the port block. master: the load/store stage plus the banks.
interface data_mem_port_if #(
    parameter int DATA_DEPTH = 8192
);
    localparam int BANK_AW = $clog2(DATA_DEPTH);

    logic                   req_valid_i;
    logic                   req_ready_o;
    logic                   req_we_i;
    logic [1:0]             req_size_i;
    logic                   req_unsigned_i;
    logic [31:0]            req_addr_i;
    logic [31:0]            req_wdata_i;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i;
    logic [31:0]            rsp_rdata_o;
    logic                   rsp_err_o;
    logic [4*BANK_AW-1:0]   bank_addr_o;
    logic [3:0]             bank_we_o;
    logic [31:0]            bank_wdata_o;
    logic [31:0]            bank_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  rsp_ready_i, bank_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output bank_addr_o, bank_we_o, bank_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output rsp_ready_i, bank_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  bank_addr_o, bank_we_o, bank_wdata_o
    );
endinterface

// File: rtl/data_mem_port.sv
// RV32I load/store to four byte-lane banks; DATA_MEM_MISALIGN_EN enables misaligned half/word accesses.
// Latency: response valid 2 cycles after the request handshake; one request in flight, issue every 3 cycles minimum.
// Backpressure: req_ready_o is low from acceptance until the response is taken; rsp held stable while rsp_ready_i is low.
module data_mem_port #(
    parameter int  DATA_DEPTH = 8192,
    localparam int BANK_AW    = $clog2(DATA_DEPTH)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    data_mem_port_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               state_q, state_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [4*BANK_AW-1:0] bank_addr_q, bank_addr_d;
    logic [3:0]           bank_we_q, bank_we_d;
    logic [31:0]          bank_wdata_q, bank_wdata_d;
    logic                 r_we_q, r_we_d;
    logic [1:0]           r_size_q, r_size_d;
    logic                 r_uns_q, r_uns_d;
    logic [1:0]           r_off_q, r_off_d;
    logic                 r_err_q, r_err_d;

    logic [1:0]           off;
    logic [BANK_AW-1:0]   row;
    logic [2:0]           nbytes;
    logic [1:0]           amask;
    logic [32:0]          last;
    logic                 fault;
    logic [1:0]           k;
    logic                 touched;
    logic [4*BANK_AW-1:0] lane_addr;
    logic [3:0]           lane_we;
    logic [31:0]          lane_wdata;
    logic [31:0]          rd, rot, ext;

    // Lane steering for the incoming request, so bank outputs are registered and valid throughout ACCESS.
    always_comb begin
        off    = bus.req_addr_i[1:0];
        row    = bus.req_addr_i[BANK_AW+1:2];
        nbytes = 3'd4;
        amask  = 2'b11;
        case (bus.req_size_i)
            2'b00:   begin nbytes = 3'd1; amask = 2'b00; end
            2'b01:   begin nbytes = 3'd2; amask = 2'b01; end
            default: begin nbytes = 3'd4; amask = 2'b11; end
        endcase
        last  = {1'b0, bus.req_addr_i} + {30'd0, nbytes} - 33'd1;
        fault = (bus.req_size_i == 2'b11) || (last >= 33'(4 * DATA_DEPTH));
`ifndef DATA_MEM_MISALIGN_EN
        fault = fault || (|(off & amask));
`endif
        k          = '0;
        touched    = 1'b0;
        lane_addr  = '0;
        lane_we    = '0;
        lane_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            k                     = 2'(i) - off;
            touched               = ({1'b0, k} < nbytes);
            lane_we[i]            = touched & bus.req_we_i & ~fault;
            lane_wdata[8*i +: 8]  = bus.req_wdata_i[8*k +: 8];
`ifdef DATA_MEM_MISALIGN_EN
            // Lanes below the offset hold the bytes that spilled into the next row.
            lane_addr[BANK_AW*i +: BANK_AW] = (touched && (2'(i) < off)) ? row + BANK_AW'(1) : row;
`else
            lane_addr[BANK_AW*i +: BANK_AW] = row;
`endif
        end
    end

    // Undo the lane rotation so access byte k lands in rsp bits 8k+7:8k, then extend.
    always_comb begin
        rd = bus.bank_rdata_i;
        case (r_off_q)
            2'd0:    rot = rd;
            2'd1:    rot = {rd[7:0],  rd[31:8]};
            2'd2:    rot = {rd[15:0], rd[31:16]};
            default: rot = {rd[23:0], rd[31:24]};
        endcase
        case (r_size_q)
            2'b00:   ext = {{24{~r_uns_q & rot[7]}},  rot[7:0]};
            2'b01:   ext = {{16{~r_uns_q & rot[15]}}, rot[15:0]};
            default: ext = rot;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        bank_addr_d  = bank_addr_q;
        bank_we_d    = '0;
        bank_wdata_d = bank_wdata_q;
        r_we_d       = r_we_q;
        r_size_d     = r_size_q;
        r_uns_d      = r_uns_q;
        r_off_d      = r_off_q;
        r_err_d      = r_err_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid_i && req_ready_q) begin
                    state_d      = ACCESS;
                    req_ready_d  = 1'b0;
                    bank_addr_d  = lane_addr;
                    bank_we_d    = lane_we;
                    bank_wdata_d = lane_wdata;
                    r_we_d       = bus.req_we_i;
                    r_size_d     = bus.req_size_i;
                    r_uns_d      = bus.req_unsigned_i;
                    r_off_d      = off;
                    r_err_d      = fault;
                end
            end
            ACCESS: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = r_err_q;
                rsp_rdata_d = (r_err_q || r_we_q) ? 32'd0 : ext;
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            bank_addr_q  <= '0;
            bank_we_q    <= '0;
            bank_wdata_q <= '0;
            r_we_q       <= 1'b0;
            r_size_q     <= '0;
            r_uns_q      <= 1'b0;
            r_off_q      <= '0;
            r_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            bank_addr_q  <= bank_addr_d;
            bank_we_q    <= bank_we_d;
            bank_wdata_q <= bank_wdata_d;
            r_we_q       <= r_we_d;
            r_size_q     <= r_size_d;
            r_uns_q      <= r_uns_d;
            r_off_q      <= r_off_d;
            r_err_q      <= r_err_d;
        end
    end

    assign bus.req_ready_o  = req_ready_q;
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_rdata_o  = rsp_rdata_q;
    assign bus.rsp_err_o    = rsp_err_q;
    assign bus.bank_addr_o  = bank_addr_q;
    assign bus.bank_we_o    = bank_we_q;
    assign bus.bank_wdata_o = bank_wdata_q;
endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port with a four-bank byte memory behind it; expectations depend on DATA_MEM_MISALIGN_EN.
module tb_data_mem_port;
    localparam int DEPTH = 8192;
    localparam int AW    = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_port_if #(.DATA_DEPTH(DEPTH)) bus();
    data_mem_port #(.DATA_DEPTH(DEPTH)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    logic [7:0] mem [4][DEPTH];
    for (genvar g = 0; g < 4; g++) begin : g_bank
        assign bus.bank_rdata_i[8*g +: 8] = mem[g][bus.bank_addr_o[AW*g +: AW]];
        always @(posedge clk)
            if (bus.bank_we_o[g]) mem[g][bus.bank_addr_o[AW*g +: AW]] <= bus.bank_wdata_o[8*g +: 8];
    end

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0]      t_rdata;
    logic             t_err;
    logic [3:0]       t_we;
    logic [4*AW-1:0]  t_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*AW-1:0] rows(input logic [AW-1:0] r3, r2, r1, r0);
        return {r3, r2, r1, r0};
    endfunction

    // One full request/response; records write lanes seen, ACCESS-cycle lane rows, response and latency.
    task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        int c;
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wdata;
        n = 0;
        while (!bus.req_ready_o && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_before_issue", 64'(bus.req_ready_o), 64'd1);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        t_we   = bus.bank_we_o;
        t_addr = bus.bank_addr_o;
        c = 0;
        while (!bus.rsp_valid_o && c < 10) begin
            @(posedge clk); #1; c++;
            t_we = t_we | bus.bank_we_o;
        end
        chk("latency", 64'(c + 1), 64'd2);
        t_rdata = bus.rsp_rdata_o;
        t_err   = bus.rsp_err_o;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
        t_we = t_we | bus.bank_we_o;
    endtask

    initial begin
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_wdata_i    = '0;
        bus.rsp_ready_i    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
        chk("rst_rsp_err",   64'(bus.rsp_err_o),   64'd0);
        chk("rst_bank_we",   64'(bus.bank_we_o),   64'd0);
        chk("rst_bank_addr", 64'(bus.bank_addr_o), 64'd0);
        chk("rst_bank_wdata", 64'(bus.bank_wdata_o), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", 64'(bus.req_ready_o), 64'd1);

        // Aligned word store and load
        xact(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        chk("sw100_we",   64'(t_we), 64'hF);
        chk("sw100_rows", 64'(t_addr), 64'(rows(13'h40, 13'h40, 13'h40, 13'h40)));
        chk("sw100_err",  64'(t_err), 64'd0);
        chk("sw100_rdata", 64'(t_rdata), 64'd0);
        xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        chk("lw100_rdata", 64'(t_rdata), 64'hDEADBEEF);
        chk("lw100_err",   64'(t_err), 64'd0);
        chk("lw100_we",    64'(t_we), 64'd0);

        // Byte store, signed and unsigned byte loads
        xact(1'b1, 2'b00, 1'b0, 32'h103, 32'h80);
        chk("sb103_we", 64'(t_we), 64'h8);
        xact(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        chk("lb103_rdata", 64'(t_rdata), 64'hFFFFFF80);
        xact(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
        chk("lbu103_rdata", 64'(t_rdata), 64'h00000080);

        // Half store and load on lanes 2,3
        xact(1'b1, 2'b01, 1'b0, 32'h102, 32'h00007F01);
        chk("sh102_we", 64'(t_we), 64'hC);
        xact(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        chk("lh102_rdata", 64'(t_rdata), 64'h00007F01);
        chk("lh102_err",   64'(t_err), 64'd0);

        // Misaligned half: bytes 0x101=BE, 0x102=01
        xact(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
`ifdef DATA_MEM_MISALIGN_EN
        chk("lh101_rdata", 64'(t_rdata), 64'h000001BE);
        chk("lh101_err",   64'(t_err), 64'd0);
`else
        chk("lh101_rdata", 64'(t_rdata), 64'd0);
        chk("lh101_err",   64'(t_err), 64'd1);
        xact(1'b1, 2'b01, 1'b0, 32'h101, 32'h5555);
        chk("sh101_we",  64'(t_we), 64'd0);
        chk("sh101_err", 64'(t_err), 64'd1);
`endif

        // Response backpressure with a second request held during ACCESS/RESP
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b0;
        bus.req_size_i  = 2'b10;
        bus.req_addr_i  = 32'h100;
        @(posedge clk); #1;
        bus.req_addr_i  = 32'h200;
        chk("bp_access_ready", 64'(bus.req_ready_o), 64'd0);
        @(posedge clk); #1;
        chk("bp_first_valid", 64'(bus.rsp_valid_o), 64'd1);
        chk("bp_first_rdata", 64'(bus.rsp_rdata_o), 64'h7F01BEEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(bus.rsp_valid_o), 64'd1);
            chk("bp_hold_rdata", 64'(bus.rsp_rdata_o), 64'h7F01BEEF);
            chk("bp_hold_ready", 64'(bus.req_ready_o), 64'd0);
        end

        // Reset while in RESP
        rst_n = 1'b0;
        #1;
        bus.req_valid_i = 1'b0;
        chk("midrst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("midrst_rsp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
        chk("midrst_req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("midrst_bank_addr", 64'(bus.bank_addr_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready_after", 64'(bus.req_ready_o), 64'd1);

        // Row-crossing misaligned word
        xact(1'b1, 2'b10, 1'b0, 32'h0FE, 32'h44332211);
`ifdef DATA_MEM_MISALIGN_EN
        chk("sw0fe_we",   64'(t_we), 64'hF);
        chk("sw0fe_rows", 64'(t_addr), 64'(rows(13'h3F, 13'h3F, 13'h40, 13'h40)));
        xact(1'b0, 2'b10, 1'b0, 32'h0FE, 32'h0);
        chk("lw0fe_rdata", 64'(t_rdata), 64'h44332211);
        chk("lw0fe_err",   64'(t_err), 64'd0);
`else
        chk("sw0fe_we",  64'(t_we), 64'd0);
        chk("sw0fe_err", 64'(t_err), 64'd1);
`endif

        // Top-row boundary
        xact(1'b1, 2'b10, 1'b0, 32'h7FFC, 32'h12345678);
        chk("sw7ffc_we",   64'(t_we), 64'hF);
        chk("sw7ffc_rows", 64'(t_addr), 64'(rows(13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF)));
        xact(1'b0, 2'b10, 1'b0, 32'h7FFC, 32'h0);
        chk("lw7ffc_rdata", 64'(t_rdata), 64'h12345678);

        // Faults
        xact(1'b1, 2'b10, 1'b0, 32'h8000, 32'hFFFFFFFF);
        chk("sw8000_err", 64'(t_err), 64'd1);
        chk("sw8000_we",  64'(t_we), 64'd0);
        xact(1'b1, 2'b10, 1'b0, 32'h7FFE, 32'hFFFFFFFF);
        chk("sw7ffe_err", 64'(t_err), 64'd1);
        chk("sw7ffe_we",  64'(t_we), 64'd0);
        xact(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
        chk("size11_err",   64'(t_err), 64'd1);
        chk("size11_rdata", 64'(t_rdata), 64'd0);
        xact(1'b0, 2'b10, 1'b0, 32'h8100, 32'h0);
        chk("lw8100_err",   64'(t_err), 64'd1);
        chk("lw8100_rdata", 64'(t_rdata), 64'd0);
        xact(1'b0, 2'b10, 1'b0, 32'h7FFC, 32'h0);
        chk("lw7ffc_intact", 64'(t_rdata), 64'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
- Initiator side of the byte-bank data memory: converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into per-lane accesses on four byte-wide memory banks.
- Accepts requests from the core's load/store stage over a valid/ready handshake.
- Steers bytes to lanes, generates per-lane write enables and row addresses, and returns extended read data on a valid/ready response channel.
- Bank i holds byte lane i (bits 8i+7:8i) of each 32-bit word.

Parameters:
- DATA_DEPTH, 8192: rows per bank. Total memory is 4*DATA_DEPTH bytes.
- BANK_AW, $clog2(DATA_DEPTH): derived row address width. Not to be overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned_i  in  1  zero-extend loads (LBU/LHU)
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_rdata_o  out  32  extended load data; 0 for stores and faults
- rsp_err_o  out  1  access fault
- bank_addr_o  out  4*BANK_AW  row address for lane i at [BANK_AW*i +: BANK_AW]
- bank_we_o  out  4  per-lane write enable
- bank_wdata_o  out  32  per-lane write byte
- bank_rdata_i  in  32  per-lane read byte (banks read combinationally)

Behaviour:
- Reset (async, rst_ni low):
  - FSM to IDLE.
  - req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, bank_we_o=0, bank_addr_o=0, bank_wdata_o=0.
  - req_ready_o rises in the first cycle after release.
- States:
  - IDLE: req_ready_o=1. On req_valid_i & req_ready_o, register all request fields and go to ACCESS.
  - ACCESS (one cycle): req_ready_o=0.
    - Drive bank_addr_o from the registered request.
    - Drive bank_we_o and bank_wdata_o for a store with no fault.
    - Capture the lane-rotated, extended bank_rdata_i (loads) and the fault flag into response registers.
    - Go to RESP.
  - RESP: rsp_valid_o=1 with stable rsp_rdata_o and rsp_err_o. On rsp_ready_i, return to IDLE.
- Timing and handshake:
  - Request-to-response latency is 2 cycles: handshake at cycle N, rsp_valid_o high at N+2.
  - Minimum issue interval is 3 cycles. No request is accepted while a response is pending.
  - bank_we_o is high only in ACCESS, for exactly one cycle per store.
  - Outside ACCESS, bank_we_o=0 and bank_addr_o/bank_wdata_o hold their last values.
- Lane mapping:
  - off = addr[1:0], row = addr[BANK_AW+1:2], nbytes = 1/2/4 by size.
  - Byte k of the access (k < nbytes) maps to lane (off+k) mod 4.
  - A lane's row is row+1 when off+k ≥ 4, otherwise row.
  - Untouched lanes are driven with row and we=0.
  - Store byte k comes from req_wdata_i[8k+7:8k].
- Load data:
  - Byte k goes to rsp_rdata_o[8k+7:8k].
  - Bits above 8*nbytes are sign-extended from the top byte, or zero-filled when req_unsigned_i=1.
  - req_unsigned_i is ignored for word accesses.
- Faults (rsp_err_o=1, no bank write, rsp_rdata_o=0):
  - req_size_i=11.
  - addr + nbytes − 1 ≥ 4*DATA_DEPTH, i.e. any addr bit above BANK_AW+1 set or the last byte beyond the top row. Rows never wrap to 0.
  - Misaligned access (off not a multiple of nbytes) when MISALIGN_EN is undefined.
- Simultaneous events:
  - A req_valid_i held during ACCESS or RESP is not accepted. The requester holds it per valid/ready.
  - rsp_ready_i high on the first RESP cycle completes in that cycle.
- Reset mid-operation: any state returns to IDLE, and a pending write is dropped if ACCESS has not yet occurred.

Optional Feature:
- Macro: DATA_MEM_MISALIGN_EN.
- Defined: misaligned half/word accesses are supported in the single ACCESS cycle using the per-lane row+1 rule, including crossing a row boundary. The top-row overrun fault still applies.
- Undefined: every misaligned half/word access faults. All lanes then use the same row, and the row+1 logic is omitted.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> bank_we_o=1111 in ACCESS at row 0x40; response 0xDEADBEEF, err 0, rsp_valid_o at handshake+2.
- SB 0x103 data 0x80, then LB 0x103 and LBU 0x103 -> bank_we_o=1000; responses 0xFFFFFF80 and 0x00000080.
- SH 0x102 data 0x7F01, LH 0x102 -> lanes 2,3 written; response 0x00007F01. LH 0x101 -> with macro: lanes 1,2, result from bytes 0x101–0x102; without macro: err=1, no write.
- With macro, SW 0x0FE data 0x44332211 -> lanes 2,3 at row 0x3F, lanes 0,1 at row 0x40; LW 0x0FE returns 0x44332211.
- Faults: SW 0x8000, SW 0x7FFE (with macro), and size=11 -> err=1, bank_we_o never asserted, rdata 0.
- Backpressure and reset: hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o/rsp_rdata_o stable, req_ready_o=0 throughout. Assert rst_ni low in RESP -> outputs cleared immediately, req_ready_o=1 on the first cycle after release.
